alu16_issue_ctrl: RTL and testbench
===================================

# alu16_issue_ctrl

Sequential front end for the 16-bit ripple-carry ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's operand and opcode inputs from registered state. It captures the ALU result and computes status flags, then returns a response over a second valid/ready handshake. It also implements 16x16 multiply (low 16 bits) as an iterative shift-add loop that reuses the ALU adder.

## Interface
Parameters:
- MUL_EN, 1, enables the multiply opcode; when 0, the multiply opcode is treated as illegal.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  4  0..7 = ALU opcode passed directly to ALU c[2:0]; 8 = MUL; 9..15 = illegal.
- req_a  in  16  operand A.
- req_b  in  16  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_y  out  16  result.
- rsp_flags  out  3  {V, N, Z}.
- rsp_err  out  1  illegal opcode.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, A and B.
  - Go to EXEC for op 0..7, to MUL for op 8 when MUL_EN=1, otherwise to RESP with y=0, flags=0, err=1.
- EXEC (1 cycle):
  - ALU inputs are a=A_reg, b=B_reg, c=op[2:0].
  - Capture yout and flags, then go to RESP.
- MUL (exactly 16 cycles, no early exit):
  - Entry: acc=0, mcand=A, mplier=B, cnt=0.
  - Each cycle: ALU a=acc, b=(mplier[0] ? mcand : 0), c=ALU_ADD.
  - Updates per cycle: acc<=yout; mcand<<=1; mplier>>=1; cnt++.
  - When cnt reaches 15, go to RESP with y=acc.
- RESP:
  - rsp_valid=1.
  - rsp_y, rsp_flags and rsp_err stay stable until rsp_ready=1, then go to IDLE.
- Flags:
  - Z = (y==0).
  - N = y[15].
  - V for ADD = (A[15]==B[15]) && (y[15]!=A[15]).
  - V for SUB = (A[15]!=B[15]) && (y[15]!=A[15]).
  - V=0 for all other ops and for MUL.
- Arithmetic is modulo 2^16; multiply carries out of bit 15 are discarded.
- req_ready=0 in every state except IDLE. Requests are not queued; the requester holds req_valid.

## Timing
- Reset: all outputs 0, state IDLE, all internal registers cleared. req_ready becomes 1 on the first cycle after rst_n deasserts.
- Reset mid-operation: the in-flight request and any pending response are discarded. rsp_valid drops asynchronously.
- Accept handshake: cycle T with req_valid && req_ready.
- ALU op latency: rsp_valid rises at T+2.
- Illegal op latency: rsp_valid rises at T+1.
- MUL latency: rsp_valid rises at T+17.
- Response handshake: cycle R with rsp_valid && rsp_ready. Earliest next accept is R+1, so steady-state ALU throughput is one op per 3 cycles.
- rsp_ready asserted before rsp_valid has no effect.
- A req_valid change while busy is ignored.

## Structure
- Shared package alu16_pkg holds:
  - ALU opcode constants, including ALU_ADD=3'b000 and ALU_SUB=3'b001 (carry-in = c[1]^c[0], so SUB injects 1).
  - OP_MUL=4'd8.
  - FSM state enum.
  - Flag bit indices.
- One sub-module: ALU_16, instantiated once. It is the only adder in the block.

## Test plan
- ADD: A=0x7FFF, B=0x0001 -> y=0x8000, flags {V=1, N=1, Z=0}, rsp_valid at T+2.
- SUB: A=0x0005, B=0x0005 -> y=0x0000, flags {V=0, N=0, Z=1}. SUB 0x8000-0x0001 -> y=0x7FFF, V=1.
- MUL: 0x0123 x 0x0045 -> y=0x4E6F at T+17. 0xFFFF x 0xFFFF -> y=0x0001. 0x0000 x 0xABCD -> y=0, Z=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_y/rsp_flags stable, req_ready=0, busy=1. Next request accepted at R+1.
- Illegal op 9 (and op 8 with MUL_EN=0) -> rsp_err=1, y=0, flags=0, rsp_valid at T+1.
- Assert rst_n=0 at MUL cycle 8 -> all outputs 0 immediately. After release, a fresh ADD 2+3 -> y=5.

Source files
------------

// File: rtl/alu16_pkg.sv
// Shared definitions for the 16-bit ALU and its sequential issue front end:
// ALU opcodes, the multiply request code, FSM states and status flag layout.
package alu16_pkg;

  // ALU opcodes on c[2:0]. The adder carry-in is c[1]^c[0], so SUB and INC
  // inject a 1 while ADD and DEC do not.
  localparam logic [2:0] ALU_ADD = 3'b000;  // a + b
  localparam logic [2:0] ALU_SUB = 3'b001;  // a - b  (a + ~b + 1)
  localparam logic [2:0] ALU_INC = 3'b010;  // a + 1  (a + 0 + 1)
  localparam logic [2:0] ALU_DEC = 3'b011;  // a - 1  (a + 0xFFFF + 0)
  localparam logic [2:0] ALU_AND = 3'b100;  // a & b
  localparam logic [2:0] ALU_OR  = 3'b101;  // a | b
  localparam logic [2:0] ALU_XOR = 3'b110;  // a ^ b
  localparam logic [2:0] ALU_NOT = 3'b111;  // ~a

  // Request opcode that selects the iterative multiply.
  localparam logic [3:0] OP_MUL = 4'd8;

  // Shift-add iterations needed for a 16x16 -> low-16 product.
  localparam int MUL_STEPS = 16;

  // Bit positions inside the {V, N, Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } alu16_state_e;

  // Opcodes 0..7 always run on the ALU; 8 runs only when multiply is built in.
  function automatic logic op_is_legal(input logic [3:0] op, input logic mul_en);
    return (op[3] == 1'b0) || ((op == OP_MUL) && mul_en);
  endfunction

  // Pack a result and its overflow bit into the {V, N, Z} flag vector.
  function automatic logic [2:0] status_flags(input logic [15:0] y, input logic v);
    logic [2:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_N] = y[15];
    f[FLAG_Z] = (y == 16'h0000);
    return f;
  endfunction

endpackage

// File: rtl/alu_16.sv
// ALU_16: combinational 16-bit ripple-carry ALU. Arithmetic ops share one
// adder whose B input and carry-in are steered by the opcode.
module alu_16
  import alu16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [2:0]  c,
  output logic [15:0] y
);

  logic [15:0] b_eff;
  logic        cin;
  logic [15:0] sum;
  logic        carry;

  // Steer the adder B operand and carry-in from the opcode.
  always_comb begin
    cin = c[1] ^ c[0];
    case (c)
      ALU_SUB: b_eff = ~b;
      ALU_INC: b_eff = 16'h0000;
      ALU_DEC: b_eff = 16'hFFFF;
      default: b_eff = b;
    endcase
  end

  // Ripple-carry adder, one full adder per bit; carry out of bit 15 is dropped.
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b_eff[i] ^ carry;
      carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
    end
  end

  // Final result select: logic ops bypass the adder.
  always_comb begin
    case (c)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOT: y = ~a;
      default: y = sum;
    endcase
  end

endmodule

// File: rtl/alu16_issue_ctrl.sv
// Sequential issue front end for the 16-bit ALU. Takes one request at a time,
// runs it on the ALU (one pass, or sixteen shift-add passes for multiply),
// then holds the registered response until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The request side is ready only while idle and is never queued;
// the response side holds rsp_y/rsp_flags/rsp_err stable while rsp_valid is
// high and rsp_ready is low.
module alu16_issue_ctrl
  import alu16_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_y,
  output logic [2:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  alu16_state_e state, state_d;

  // a_reg/b_reg hold the operands; during multiply they double as the
  // shifting multiplicand (a_reg) and multiplier (b_reg).
  logic [2:0]  op_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] y_reg;
  logic [2:0]  flags_reg;
  logic        err_reg;

  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_c;
  logic [15:0] alu_y;
  logic        req_legal;
  logic        mul_last;
  logic        exec_v;

  assign req_legal = op_is_legal(req_op, MUL_EN);
  assign mul_last  = (cnt == 4'(MUL_STEPS - 1));

  alu_16 u_alu_16 (
    .a (alu_a),
    .b (alu_b),
    .c (alu_c),
    .y (alu_y)
  );

  // Next-state logic, handshake outputs and ALU input steering.
  always_comb begin
    state_d   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    alu_a     = a_reg;
    alu_b     = b_reg;
    alu_c     = op_reg;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = rst_n;
        if (req_valid) begin
          if (!req_legal)            state_d = ST_RESP;
          else if (req_op == OP_MUL) state_d = ST_MUL;
          else                       state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_MUL: begin
        alu_a = acc;
        alu_b = b_reg[0] ? a_reg : 16'h0000;
        alu_c = ALU_ADD;
        if (mul_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Signed overflow applies only to ADD and SUB; other ops report V=0.
  always_comb begin
    exec_v = 1'b0;
    if (op_reg == ALU_ADD)
      exec_v = (a_reg[15] == b_reg[15]) && (alu_y[15] != a_reg[15]);
    else if (op_reg == ALU_SUB)
      exec_v = (a_reg[15] != b_reg[15]) && (alu_y[15] != a_reg[15]);
  end

  // State register; reset discards any in-flight request or response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Operand capture, multiply iteration and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      y_reg     <= '0;
      flags_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_reg <= req_op[2:0];
            a_reg  <= req_a;
            b_reg  <= req_b;
            acc    <= '0;
            cnt    <= '0;
            if (!req_legal) begin
              y_reg     <= '0;
              flags_reg <= '0;
              err_reg   <= 1'b1;
            end else begin
              err_reg <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          y_reg     <= alu_y;
          flags_reg <= status_flags(alu_y, exec_v);
        end
        ST_MUL: begin
          acc   <= alu_y;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 4'd1;
          if (mul_last) begin
            y_reg     <= alu_y;
            flags_reg <= status_flags(alu_y, 1'b0);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_y     = y_reg;
  assign rsp_flags = flags_reg;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_alu16_issue_ctrl.sv
// Self-checking bench for alu16_issue_ctrl: directed cases with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of results and response timing.
module tb_alu16_issue_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b, rsp_y;
  logic [2:0]  rsp_flags;

  logic        nm_req_valid, nm_req_ready, nm_rsp_valid, nm_rsp_ready, nm_rsp_err, nm_busy;
  logic [3:0]  nm_req_op;
  logic [15:0] nm_req_a, nm_req_b, nm_rsp_y;
  logic [2:0]  nm_rsp_flags;

  alu16_issue_ctrl #(.MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  alu16_issue_ctrl #(.MUL_EN(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n),
    .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_op(nm_req_op),
    .req_a(nm_req_a), .req_b(nm_req_b),
    .rsp_valid(nm_rsp_valid), .rsp_ready(nm_rsp_ready), .rsp_y(nm_rsp_y),
    .rsp_flags(nm_rsp_flags), .rsp_err(nm_rsp_err), .busy(nm_busy)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [19:0] exp_q[$];   // {err, V, N, Z, y} per accepted request
  bit pending = 1'b0;
  bit settle  = 1'b0;
  int cyc = 0;
  int t_acc = 0;
  int lat_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result model from the operation definitions: {err, V, N, Z, y}.
  function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, r;
    logic [31:0] p;
    logic [15:0] y;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = 1'b0;
    y  = 16'h0000;
    case (op)
      4'd0: begin r = sa + sb; y = a + b; v = (r > 32767) || (r < -32768); end
      4'd1: begin r = sa - sb; y = a - b; v = (r > 32767) || (r < -32768); end
      4'd2: y = a + 16'd1;
      4'd3: y = a - 16'd1;
      4'd4: y = a & b;
      4'd5: y = a | b;
      4'd6: y = a ^ b;
      4'd7: y = ~a;
      4'd8: begin p = 32'(a) * 32'(b); y = p[15:0]; end
      default: return {1'b1, 3'b000, 16'h0000};
    endcase
    return {1'b0, v, y[15], (y == 16'h0000), y};
  endfunction

  function automatic int latency(input logic [3:0] op);
    if (op < 4'd8)  return 2;
    if (op == 4'd8) return 17;
    return 1;
  endfunction

  // Per-cycle compare against the transaction model (sampled mid-cycle).
  always @(negedge clk) begin
    logic exp_v;
    logic [19:0] e;
    if (!rst_n) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_y", 32'(rsp_y), 32'd0);
      check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      pending = 1'b0;
      exp_q.delete();
      settle = 1'b1;
    end else if (settle) begin
      settle = 1'b0;
      check("settle_rsp_valid", 32'(rsp_valid), 32'd0);
      check("settle_busy", 32'(busy), 32'd0);
    end else begin
      exp_v = pending && (cyc >= t_acc + lat_exp);
      check("req_ready", 32'(req_ready), 32'(!pending));
      check("busy", 32'(busy), 32'(pending));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v && rsp_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        check("rsp_y", 32'(rsp_y), 32'(e[15:0]));
        check("rsp_flags", 32'(rsp_flags), 32'(e[18:16]));
        check("rsp_err", 32'(rsp_err), 32'(e[19]));
      end
      if (exp_v && rsp_ready) begin
        pending = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (!pending && req_valid) begin
        pending = 1'b1;
        t_acc   = cyc;
        lat_exp = latency(req_op);
        exp_q.push_back(model(req_op, req_a, req_b));
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Random request-side noise while the block is busy; it must be ignored.
  task automatic scribble();
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 4'($urandom_range(0, 15));
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
  endtask

  task automatic do_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit early,
                        output logic [15:0] y, output logic [2:0] fl, output logic e,
                        output int lat, output int wait_rdy);
    y = '0; fl = '0; e = 1'b0; lat = 0; wait_rdy = 0;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b0;
    while (req_ready !== 1'b1 && wait_rdy < 50) begin
      wait_cycle();
      wait_rdy++;
    end
    if (req_ready !== 1'b1) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    wait_cycle();
    lat = 1;
    rsp_ready = early;
    scribble();
    while (rsp_valid !== 1'b1 && lat < 40) begin
      wait_cycle();
      lat++;
      scribble();
    end
    if (rsp_valid !== 1'b1) begin
      check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      return;
    end
    y = rsp_y; fl = rsp_flags; e = rsp_err;
    if (!early) begin
      repeat (hold) begin
        wait_cycle();
        scribble();
      end
      rsp_ready = 1'b1;
    end
    wait_cycle();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] y;
    logic [2:0]  fl;
    logic        e;
    int          lat, wr;
    logic [3:0]  rop;

    req_valid = 0; req_op = 0; req_a = 0; req_b = 0; rsp_ready = 0;
    nm_req_valid = 0; nm_req_op = 0; nm_req_a = 0; nm_req_b = 0; nm_rsp_ready = 0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycle();

    // Multiply opcode on a build without multiply: illegal, response next cycle.
    nm_req_op = 4'd8; nm_req_a = 16'h0123; nm_req_b = 16'h0045; nm_req_valid = 1'b1;
    check("nm_req_ready", 32'(nm_req_ready), 32'd1);
    wait_cycle();
    nm_req_valid = 1'b0;
    check("nm_rsp_valid_t1", 32'(nm_rsp_valid), 32'd1);
    check("nm_rsp_err", 32'(nm_rsp_err), 32'd1);
    check("nm_rsp_y", 32'(nm_rsp_y), 32'd0);
    check("nm_rsp_flags", 32'(nm_rsp_flags), 32'd0);
    nm_rsp_ready = 1'b1;
    wait_cycle();
    nm_rsp_ready = 1'b0;
    check("nm_idle_busy", 32'(nm_busy), 32'd0);
    check("nm_idle_ready", 32'(nm_req_ready), 32'd1);

    // Directed cases with hand-computed results.
    do_req(4'd0, 16'h7FFF, 16'h0001, 0, 1'b0, y, fl, e, lat, wr);
    check("add_ovf_y", 32'(y), 32'h8000);
    check("add_ovf_flags", 32'(fl), 32'b110);
    check("add_ovf_err", 32'(e), 32'd0);
    check("add_latency", 32'(lat), 32'd2);

    do_req(4'd1, 16'h0005, 16'h0005, 0, 1'b0, y, fl, e, lat, wr);
    check("sub_zero_y", 32'(y), 32'h0000);
    check("sub_zero_flags", 32'(fl), 32'b001);

    do_req(4'd1, 16'h8000, 16'h0001, 0, 1'b0, y, fl, e, lat, wr);
    check("sub_ovf_y", 32'(y), 32'h7FFF);
    check("sub_ovf_flags", 32'(fl), 32'b100);

    do_req(4'd8, 16'h0123, 16'h0045, 0, 1'b0, y, fl, e, lat, wr);
    check("mul_y", 32'(y), 32'h4E6F);
    check("mul_flags", 32'(fl), 32'b000);
    check("mul_latency", 32'(lat), 32'd17);

    do_req(4'd8, 16'hFFFF, 16'hFFFF, 0, 1'b0, y, fl, e, lat, wr);
    check("mul_ffff_y", 32'(y), 32'h0001);

    do_req(4'd8, 16'h0000, 16'hABCD, 0, 1'b0, y, fl, e, lat, wr);
    check("mul_zero_y", 32'(y), 32'h0000);
    check("mul_zero_flags", 32'(fl), 32'b001);

    // Backpressure: response held for 5 cycles, next request at R+1.
    do_req(4'd0, 16'h1234, 16'h1111, 5, 1'b0, y, fl, e, lat, wr);
    check("bp_add_y", 32'(y), 32'h2345);
    do_req(4'd2, 16'h00FF, 16'h0000, 0, 1'b0, y, fl, e, lat, wr);
    check("bp_next_accept_wait", 32'(wr), 32'd0);
    check("inc_y", 32'(y), 32'h0100);

    do_req(4'd9, 16'h1234, 16'h5678, 0, 1'b0, y, fl, e, lat, wr);
    check("illegal_err", 32'(e), 32'd1);
    check("illegal_y", 32'(y), 32'd0);
    check("illegal_flags", 32'(fl), 32'd0);
    check("illegal_latency", 32'(lat), 32'd1);

    // Reset in the middle of a multiply (MUL cycle 8).
    req_op = 4'd8; req_a = 16'h1234; req_b = 16'h5678; req_valid = 1'b1;
    check("rst_test_accept", 32'(req_ready), 32'd1);
    wait_cycle();
    req_valid = 1'b0;
    repeat (8) wait_cycle();
    check("mid_mul_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd0);
    check("async_rst_rsp_y", 32'(rsp_y), 32'd0);
    wait_cycle();
    wait_cycle();
    rst_n = 1'b1;
    wait_cycle();
    do_req(4'd0, 16'h0002, 16'h0003, 0, 1'b0, y, fl, e, lat, wr);
    check("post_rst_add_y", 32'(y), 32'h0005);

    // Randomized traffic; the per-cycle compare checks every response.
    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      do_req(rop, 16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             y, fl, e, lat, wr);
      repeat ($urandom_range(0, 2)) wait_cycle();
    end

    wait_cycle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks bad", n_bad, n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
